// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Bytes enter through a valid/ready handshake into
//   a circular FIFO and are serialised LSB first onto txd as 8N1 frames (8E1
//   when UART_TX_PARITY_EN is defined). The bit period is DIV = CLK_FREQ / BAUD
//   system clocks, so no separate baud clock is needed.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   : PARITY state compiled in, even-parity bit sent after DATA.
//     undefined : no PARITY state or parity logic, 8N1 frames.
//
//   Parameters
//     CLK_FREQ   : system clock frequency in Hz
//     BAUD       : line rate in bit/s (DIV must come out >= 2)
//     FIFO_DEPTH : FIFO entries, power of 2, >= 2
//
//   Ports
//     clk      in   system clock
//     rst      in   asynchronous active-low reset
//     d_tx     in   byte to transmit
//     vld_tx   in   d_tx is valid
//     rdy_tx   out  FIFO can accept a byte this cycle
//     txd      out  serial line, idle high, registered
//     busy     out  frame in progress or FIFO non-empty
//     fifo_cnt out  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    d_tx,
    input  logic                          vld_tx,
    output logic                          rdy_tx,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(DIV);

    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    state_t        state, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic          txd_q, txd_d;
    logic          push, pop, baud_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // Ready comes from registered occupancy only: no bypass when full.
    assign rdy_tx   = (cnt != FULL_CNT);
    assign push     = vld_tx && rdy_tx;
    assign busy     = (state != IDLE) || (cnt != '0);
    assign fifo_cnt = cnt;
    assign txd      = txd_q;

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_tx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        pop      = 1'b0;
        baud_end = (baud_q == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state)
            IDLE: begin
                if (cnt != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem[rd_ptr];
`endif
                end
            end
            START: begin
                if (baud_end) state_d = DATA;
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // txd is registered, so its next value is decoded from next state;
        // this makes the line fall on the same edge as the pop.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with DIV = 10. Stimulus pushes expected
//   bytes into a scoreboard queue; an independent line monitor decodes frames
//   from txd and compares them against the queue. Timing-specific items are
//   checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
    int seq1 [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
`else
    localparam int FRAME = 10 * DIV;
    int seq1 [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [7:0] d_tx   = '0;
    logic       vld_tx = 1'b0;
    logic       rdy_tx;
    logic       txd;
    logic       busy;
    logic [4:0] fifo_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rst_gen  = 0;
    bit mon_busy = 1'b0;

    logic [7:0] exp_q [$];
    int         starts_q [$];
    int         par_q [$];

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_tx     (d_tx),
        .vld_tx   (vld_tx),
        .rdy_tx   (rdy_tx),
        .txd      (txd),
        .busy     (busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge with vld_tx still high.
    task automatic send(input logic [7:0] b);
        bit ok;
        int n;
        n      = 0;
        d_tx   = b;
        vld_tx = 1'b1;
        do begin
            ok = rdy_tx;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 500);
        check("send_accept", int'(ok), 1);
        if (ok) exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || mon_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", int'(busy || mon_busy), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Line monitor: samples each bit mid-period, compares with scoreboard.
    initial begin : monitor
        int         g;
        logic [7:0] data;
        logic [7:0] e;
        logic       sb;
        logic       stb;
`ifdef UART_TX_PARITY_EN
        logic       pb;
`endif
        forever begin
            @(negedge clk);
            if (rst && txd === 1'b0) begin
                mon_busy = 1'b1;
                g        = rst_gen;
                starts_q.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    data[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                pb = txd;
`endif
                repeat (DIV) @(negedge clk);
                stb = txd;
                if (g == rst_gen && rst) begin
                    check("mon_start_bit", int'(sb), 0);
                    check("mon_stop_bit", int'(stb), 1);
`ifdef UART_TX_PARITY_EN
                    check("mon_parity", int'(pb), int'(^data));
                    par_q.push_back(int'(pb));
`endif
                    check("mon_frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("mon_data", int'(data), int'(e));
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int zeros;

        // ---- Reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", int'(txd), 1);
        check("rst_rdy", int'(rdy_tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(fifo_cnt), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---- 1: single 0x55 frame, exact line waveform and busy drop ----
        send(8'h55);
        vld_tx = 1'b0;
        @(negedge clk);
        check("t1_txd_before_pop", int'(txd), 1);
        for (int k = 0; k < FRAME + 10; k++) begin
            @(negedge clk);
            check($sformatf("t1_line_%0d", k), int'(txd), seq1[k / 10]);
            check($sformatf("t1_busy_%0d", k), int'(busy), int'(k < FRAME));
        end
        @(posedge clk);
        #1;
        wait_idle();

        // ---- 2/6: fill to full behind a running frame, pop at full ----
        send(8'h5A);
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        check("t2_full_cnt", int'(fifo_cnt), 16);
        check("t2_full_rdy", int'(rdy_tx), 0);
        d_tx   = 8'h20;
        vld_tx = 1'b1;
        n      = 0;
        while (fifo_cnt == 5'd16 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_pop_at_full_cnt", int'(fifo_cnt), 15);
        check("t6_pop_at_full_rdy", int'(rdy_tx), 1);
        @(posedge clk);
        #1;
        check("t2_late_accept_cnt", int'(fifo_cnt), 16);
        exp_q.push_back(8'h20);
        vld_tx = 1'b0;
        wait_idle();

        // ---- 3: back-to-back frames, start spacing ----
        starts_q.delete();
        send(8'hA3);
        send(8'h0F);
        vld_tx = 1'b0;
        wait_idle();
        check("t3_frames", starts_q.size(), 2);
        if (starts_q.size() == 2)
            check("t3_start_spacing", starts_q[1] - starts_q[0], FRAME + 1);

        // ---- 4: asynchronous reset during DATA bit 3 ----
        send(8'hFF);
        send(8'h81);
        vld_tx = 1'b0;
        repeat (43) @(posedge clk);
        #3;
        rst = 1'b0;
        rst_gen++;
        exp_q.delete();
        #1;
        check("t4_rst_txd", int'(txd), 1);
        check("t4_rst_cnt", int'(fifo_cnt), 0);
        check("t4_rst_busy", int'(busy), 0);
        check("t4_rst_rdy", int'(rdy_tx), 1);
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        zeros = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        check("t4_no_activity", zeros, 0);
        check("t4_busy_after", int'(busy), 0);
        @(posedge clk);
        #1;
        wait_idle();

`ifdef UART_TX_PARITY_EN
        // ---- 5: even parity on 0x07, 11-bit frames ----
        starts_q.delete();
        par_q.delete();
        send(8'h07);
        send(8'h07);
        vld_tx = 1'b0;
        wait_idle();
        check("t5_frames", starts_q.size(), 2);
        if (starts_q.size() == 2)
            check("t5_start_spacing", starts_q[1] - starts_q[0], 111);
        check("t5_par_count", par_q.size(), 2);
        if (par_q.size() > 0)
            check("t5_parity_bit", par_q[0], 1);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
